// File: rtl/apu_pkg.sv
// Shared definitions for the audio frame sequencer and its helpers.
package apu_pkg;

    localparam int APU_STEPS = 8;

    typedef logic [2:0] fs_step_t;

    // Tick masks, bit index = step value being executed.
    localparam logic [7:0] LEN_STEPS = 8'b0101_0101;
    localparam logic [7:0] SWP_STEPS = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS = 8'b1000_0000;

    typedef struct packed {
        logic length;
        logic sweep;
        logic env;
    } fs_ticks_t;

    // Which step clocks fire when the given step is executed.
    function automatic fs_ticks_t decode_step(input fs_step_t s);
        fs_ticks_t t;
        t.length = LEN_STEPS[s];
        t.sweep  = SWP_STEPS[s];
        t.env    = ENV_STEPS[s];
        return t;
    endfunction

endpackage

// File: rtl/apu_prescaler.sv
// 512 Hz base strobe source: internal prescaler or falling edge of an external DIV bit.
module apu_prescaler
    import apu_pkg::*;
#(
    parameter int PRESCALE   = 32768,
    parameter int PRESCALE_W = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sound_en,
    input  logic div_sel,
    input  logic div_bit,
    output logic strobe_512
);

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] count;
    logic                  div_q;
    logic                  int_strobe;
    logic                  ext_strobe;

    // DIV bit is registered in every mode so a mode switch never sees a stale edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= 1'b0;
        end else begin
            div_q <= div_bit;
        end
    end

    // Prescaler counts only while enabled in internal mode; otherwise it sits at 0 so a switch restarts it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!sound_en || div_sel) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign int_strobe = (count == LAST);
    assign ext_strobe = div_q & ~div_bit;
    assign strobe_512 = div_sel ? ext_strobe : int_strobe;

endmodule

// File: rtl/apu_frame_sequencer.sv
// Frame sequencer: walks the 8-step sequence on each 512 Hz strobe and emits
// one-cycle length, sweep and envelope tick strobes.
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int PRESCALE   = 32768,
    parameter int PRESCALE_W = 15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sound_en,
    input  logic       div_sel,
    input  logic       div_bit,
    output logic [2:0] step,
    output logic       length_phase,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       env_tick
);

    localparam fs_step_t LAST_STEP = fs_step_t'(APU_STEPS - 1);

    logic      strobe_512;
    fs_step_t  step_q;
    fs_ticks_t ticks_q;
    fs_ticks_t ticks_next;

    apu_prescaler #(
        .PRESCALE   (PRESCALE),
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clock      (clock),
        .reset_n    (reset_n),
        .sound_en   (sound_en),
        .div_sel    (div_sel),
        .div_bit    (div_bit),
        .strobe_512 (strobe_512)
    );

    // Tick pattern for the step about to be executed.
    always_comb begin
        ticks_next = decode_step(step_q);
    end

    // Step counter and tick registers; disable forces everything idle, even a coincident strobe.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_q  <= '0;
            ticks_q <= '0;
        end else if (!sound_en) begin
            step_q  <= '0;
            ticks_q <= '0;
        end else if (strobe_512) begin
            ticks_q <= ticks_next;
            if (step_q == LAST_STEP) begin
                step_q <= '0;
            end else begin
                step_q <= step_q + 1'b1;
            end
        end else begin
            ticks_q <= '0;
        end
    end

    assign step         = step_q;
    assign length_phase = step_q[0];
    assign length_tick  = ticks_q.length;
    assign sweep_tick   = ticks_q.sweep;
    assign env_tick     = ticks_q.env;

endmodule
